// File: rtl/alu_nibble_serial_if.sv
// Handshake and data bundle for alu_nibble_serial.
// The slave modport is the ALU side; master is the producer/consumer side.
// Optional macro ALU_OVF_EN adds the signed-overflow flag ovf.
interface alu_nibble_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [4:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             carry_out;
    logic             zero;
    logic             all_ones;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, d1, d2, ctrl, out_ready,
        output
`ifdef ALU_OVF_EN
               ovf,
`endif
               in_ready, out_valid, res, carry_out, zero, all_ones
    );

    modport master (
        output in_valid, d1, d2, ctrl, out_ready,
        input
`ifdef ALU_OVF_EN
               ovf,
`endif
               in_ready, out_valid, res, carry_out, zero, all_ones
    );
endinterface

// File: rtl/alu_nibble_serial.sv
// Nibble-serial ALU: a WIDTH-bit operation runs as WIDTH/4 slices through one
// shared 4-bit datapath, one slice per clock, with the inter-slice carry or
// shift bit held in a register. Valid/ready handshakes on both sides.
// Optional macro ALU_OVF_EN adds the signed-overflow output ovf.
module alu_nibble_serial #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    alu_nibble_serial_if.slave bus
);
    localparam int NSL = WIDTH / 4;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("alu_nibble_serial: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic             cd_reg;
    logic [1:0]       op_reg;
    logic             c_reg;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_out_r;
    logic             zero_r;
    logic             all_ones_r;

    logic [CW-1:0]    idx;
    int unsigned      base;
    logic [3:0]       a_n;
    logic [3:0]       b_n;
    logic [4:0]       cc;
    logic [3:0]       sum;
    logic [3:0]       slice_out;
    logic             c_next;
    logic             carry_sel;
    logic             last;
    logic [WIDTH-1:0] merged;

    // Shared 4-bit slice: select the active nibble, compute it, merge into the result
    always_comb begin
        idx       = (op_reg == 2'b11) ? (CW'(NSL - 1) - cnt) : cnt;
        base      = 4 * int'(idx);
        a_n       = a_reg[base +: 4];
        b_n       = b_reg[base +: 4];
        cc        = '0;
        sum       = '0;
        cc[0]     = cd_reg ? 1'b0 : c_reg;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]  = a_n[i] ^ b_n[i] ^ cc[i];
            cc[i+1] = cd_reg ? 1'b0
                             : ((a_n[i] & b_n[i]) | (a_n[i] & cc[i]) | (b_n[i] & cc[i]));
        end
        slice_out = sum;
        c_next    = c_reg;
        case (op_reg)
            2'b00: begin
                slice_out = sum;
                c_next    = cd_reg ? c_reg : cc[4];
            end
            2'b01:   slice_out = a_n & b_n;
            2'b10:   slice_out = a_n | b_n;
            default: begin
                slice_out = {c_reg, b_n[3:1]};
                c_next    = b_n[0];
            end
        endcase
        carry_sel = ((op_reg == 2'b00) && !cd_reg) || (op_reg == 2'b11) ? c_next : 1'b0;
        last      = (cnt == CW'(NSL - 1));
        merged    = acc;
        merged[base +: 4] = slice_out;
    end

`ifdef ALU_OVF_EN
    logic ovf_r;
`endif

    // Control FSM with registered handshake outputs and result/flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            cd_reg      <= 1'b0;
            op_reg      <= '0;
            c_reg       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            res_r       <= '0;
            carry_out_r <= 1'b0;
            zero_r      <= 1'b0;
            all_ones_r  <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.d1;
                        b_reg      <= bus.d2 ^ {WIDTH{bus.ctrl[3]}};
                        cd_reg     <= bus.ctrl[2];
                        op_reg     <= bus.ctrl[1:0];
                        c_reg      <= bus.ctrl[4];
                        cnt        <= '0;
                        acc        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc   <= merged;
                    c_reg <= c_next;
                    if (last) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        res_r       <= merged;
                        zero_r      <= (merged == '0);
                        all_ones_r  <= (merged == '1);
                        carry_out_r <= carry_sel;
`ifdef ALU_OVF_EN
                        ovf_r       <= ((op_reg == 2'b00) && !cd_reg) ? (cc[3] ^ cc[4]) : 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.res       = res_r;
    assign bus.carry_out = carry_out_r;
    assign bus.zero      = zero_r;
    assign bus.all_ones  = all_ones_r;
`ifdef ALU_OVF_EN
    assign bus.ovf       = ovf_r;
`endif
endmodule

// File: tb/tb_alu_nibble_serial.sv
// Directed bench for alu_nibble_serial at WIDTH 16, 4 and 32.
module tb_alu_nibble_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_nibble_serial_if #(.WIDTH(16)) bus16 ();
    alu_nibble_serial_if #(.WIDTH(4))  bus4 ();
    alu_nibble_serial_if #(.WIDTH(32)) bus32 ();

    alu_nibble_serial #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    alu_nibble_serial #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    alu_nibble_serial #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [4:0]  ctrl;
        logic [15:0] res;
        logic        co;
        logic        z;
        logic        ones;
        logic        ovf;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op on the 16-bit DUT; lat = posedges from capture to out_valid
    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] c, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus16.in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        bus16.d1 = a;
        bus16.d2 = b;
        bus16.ctrl = c;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release16;
        bus16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.out_ready = 1'b0;
    endtask

    initial begin : main
        int lat;
        vt[0]  = '{"add",      16'h1234, 16'h0FFF, 5'b00000, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{"add_wrap", 16'hFFFF, 16'h0001, 5'b00000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{"sub_brw",  16'h0005, 16'h0007, 5'b11000, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{"comp_eq",  16'h1234, 16'h1234, 5'b01000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{"comp_gt",  16'h1235, 16'h1234, 5'b01000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{"rshft",    16'h0000, 16'h8001, 5'b10111, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{"xnor",     16'h0000, 16'h00F0, 5'b01100, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{"and",      16'hF0F0, 16'h3C3C, 5'b00101, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{"or",       16'hF000, 16'h000F, 5'b00110, 16'hF00F, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{"xor_cin",  16'hFFFF, 16'h0F0F, 5'b10100, 16'hF0F0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{"rshft_a",  16'hFFFF, 16'h1234, 5'b00111, 16'h091A, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{"sub_nb",   16'h000A, 16'h0003, 5'b11000, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[12] = '{"add_cin",  16'h00FF, 16'h0001, 5'b10000, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[13] = '{"add_ovf",  16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[14] = '{"sub_ovf",  16'h8000, 16'h0001, 5'b11000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[15] = '{"or_ones",  16'h5555, 16'hAAAA, 5'b00110, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};

        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.d1 = '0; bus16.d2 = '0; bus16.ctrl = '0;
        bus4.in_valid  = 1'b0; bus4.out_ready  = 1'b0; bus4.d1  = '0; bus4.d2  = '0; bus4.ctrl  = '0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.d1 = '0; bus32.d2 = '0; bus32.ctrl = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus16.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("rst_res", 64'(bus16.res), 64'd0);
        check("rst_carry", 64'(bus16.carry_out), 64'd0);
        check("rst_zero", 64'(bus16.zero), 64'd0);
        check("rst_ones", 64'(bus16.all_ones), 64'd0);
`ifdef ALU_OVF_EN
        check("rst_ovf", 64'(bus16.ovf), 64'd0);
`endif
        rst_n = 1'b1;

        // Table-driven vectors on the 16-bit instance
        for (int i = 0; i < 16; i++) begin
            issue16(vt[i].d1, vt[i].d2, vt[i].ctrl, lat);
            check({vt[i].name, "_lat"}, 64'(lat), 64'd4);
            check({vt[i].name, "_res"}, 64'(bus16.res), 64'(vt[i].res));
            check({vt[i].name, "_co"}, 64'(bus16.carry_out), 64'(vt[i].co));
            check({vt[i].name, "_zero"}, 64'(bus16.zero), 64'(vt[i].z));
            check({vt[i].name, "_ones"}, 64'(bus16.all_ones), 64'(vt[i].ones));
            check({vt[i].name, "_inrdy"}, 64'(bus16.in_ready), 64'd0);
`ifdef ALU_OVF_EN
            check({vt[i].name, "_ovf"}, 64'(bus16.ovf), 64'(vt[i].ovf));
`endif
            release16();
        end

        // Backpressure: DONE holds, new in_valid ignored
        issue16(16'h1234, 16'h0FFF, 5'b00000, lat);
        for (int k = 0; k < 3; k++) begin
            bus16.d1 = 16'hAAAA;
            bus16.d2 = 16'h5555;
            bus16.ctrl = 5'b00110;
            bus16.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("bp_res", 64'(bus16.res), 64'h2233);
            check("bp_valid", 64'(bus16.out_valid), 64'd1);
            check("bp_inrdy", 64'(bus16.in_ready), 64'd0);
        end
        bus16.in_valid = 1'b0;
        release16();
        check("bp_rel_inrdy", 64'(bus16.in_ready), 64'd1);
        check("bp_rel_valid", 64'(bus16.out_valid), 64'd0);
        check("bp_rel_res_hold", 64'(bus16.res), 64'h2233);
        @(posedge clk);
        @(negedge clk);
        check("bp_no_capture", 64'(bus16.in_ready), 64'd1);

        // WIDTH=4: single RUN cycle
        bus4.d1 = 4'h4; bus4.d2 = 4'hF; bus4.ctrl = 5'b00000; bus4.in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        while (!bus4.out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("w4_lat", 64'(lat), 64'd1);
        check("w4_res", 64'(bus4.res), 64'h3);
        check("w4_co", 64'(bus4.carry_out), 64'd1);
        bus4.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus4.out_ready = 1'b0;

        // WIDTH=32: eight slices
        bus32.d1 = 32'h1234_1234; bus32.d2 = 32'h0FFF_0FFF; bus32.ctrl = 5'b00000; bus32.in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        while (!bus32.out_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("w32_lat", 64'(lat), 64'd8);
        check("w32_res", 64'(bus32.res), 64'h2233_2233);
        check("w32_co", 64'(bus32.carry_out), 64'd0);
        bus32.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus32.out_ready = 1'b0;

        // Asynchronous reset while at RUN slice 2
        bus16.d1 = 16'hFFFF; bus16.d2 = 16'h0001; bus16.ctrl = 5'b00000; bus16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus16.out_valid), 64'd0);
        check("arst_inrdy", 64'(bus16.in_ready), 64'd1);
        check("arst_res", 64'(bus16.res), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_no_result", 64'(bus16.out_valid), 64'd0);
        issue16(16'h1234, 16'h0FFF, 5'b00000, lat);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_res", 64'(bus16.res), 64'h2233);
        check("post_rst_co", 64'(bus16.carry_out), 64'd0);
        release16();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
